// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with round-robin replacement and flush sequencer
module btb_assoc #(
  parameter int INDEX_WIDTH = 8,
  parameter int WAYS = 2,
  localparam int SETS = 2 ** INDEX_WIDTH,
  localparam int TAG_W = 32 - INDEX_WIDTH - 2,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      lookup_pc_i,
  output logic             hit_o,
  output logic [31:0]      target_o,
  output logic [WAY_W-1:0] hit_way_o,
  input  logic             upd_en_i,
  input  logic [31:0]      upd_pc_i,
  input  logic [31:0]      upd_target_i,
  input  logic             flush_i,
  output logic             busy_o
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state_q, state_d;
  logic [INDEX_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [WAYS-1:0] valid_q [SETS];
  logic [TAG_W-1:0] tag_q [SETS][WAYS];
  logic [31:0] tgt_q [SETS][WAYS];
  logic [WAY_W-1:0] rr_q [SETS];
  logic [INDEX_WIDTH-1:0] lk_set, up_set;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic up_hit, up_free, up_evict, upd_go;
  logic [WAY_W-1:0] up_hw, up_fw, up_way, rr_inc;
  logic unused_pc;
  assign unused_pc = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};
  assign lk_set = lookup_pc_i[INDEX_WIDTH+1:2];
  assign lk_tag = lookup_pc_i[31:INDEX_WIDTH+2];
  assign up_set = upd_pc_i[INDEX_WIDTH+1:2];
  assign up_tag = upd_pc_i[31:INDEX_WIDTH+2];
  assign busy_o = state_q == FLUSH;
  always_comb begin
    hit_o = 1'b0;
    target_o = '0;
    hit_way_o = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag && !busy_o) begin
        hit_o = 1'b1;
        target_o = tgt_q[lk_set][w];
        hit_way_o = WAY_W'(w);
      end
  end
  // descending scan leaves the lowest-numbered invalid way in up_fw
  always_comb begin
    up_hit = 1'b0;
    up_hw = '0;
    up_free = 1'b0;
    up_fw = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[up_set][w]) begin
        up_free = 1'b1;
        up_fw = WAY_W'(w);
      end
      if (valid_q[up_set][w] && tag_q[up_set][w] == up_tag) begin
        up_hit = 1'b1;
        up_hw = WAY_W'(w);
      end
    end
  end
  assign up_way = up_hit ? up_hw : up_free ? up_fw : rr_q[up_set];
  assign up_evict = !up_hit && !up_free;
  assign rr_inc = (WAYS == 1) ? '0 : rr_q[up_set] + 1'b1;
  assign upd_go = upd_en_i && state_q == IDLE && !flush_i;
  always_comb begin
    state_d = state_q;
    fcnt_d = fcnt_q;
    if (state_q == IDLE && flush_i) begin
      state_d = FLUSH;
      fcnt_d = '0;
    end else if (state_q == FLUSH) begin
      fcnt_d = fcnt_q + 1'b1;
      state_d = (fcnt_q == INDEX_WIDTH'(SETS - 1)) ? IDLE : FLUSH;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      fcnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      fcnt_q <= fcnt_d;
      if (state_q == FLUSH) begin
        valid_q[fcnt_q] <= '0;
        rr_q[fcnt_q] <= '0;
      end else if (upd_go) begin
        valid_q[up_set][up_way] <= 1'b1;
        if (up_evict) rr_q[up_set] <= rr_inc;
      end
    end
  end
  // tag/target storage carries no reset; the valid bits gate their use
  always_ff @(posedge clk_i) begin
    if (upd_go && !rst_i) begin
      tgt_q[up_set][up_way] <= upd_target_i;
      if (!up_hit) tag_q[up_set][up_way] <= up_tag;
    end
  end
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed table, flush/reset sequences and randomized model check for btb_assoc
module tb_btb_assoc;
  localparam int IW = 4;
  localparam int WAYS = 2;
  localparam int SETS = 16;
  logic clk = 1'b0, rst = 1'b0, upd = 1'b0, flush = 1'b0;
  logic [31:0] look = '0, upd_pc = '0, upd_tgt = '0;
  logic hit, busy;
  logic [31:0] tgt;
  logic way;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  btb_assoc #(.INDEX_WIDTH(IW), .WAYS(WAYS)) dut (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(look), .hit_o(hit), .target_o(tgt),
    .hit_way_o(way), .upd_en_i(upd), .upd_pc_i(upd_pc), .upd_target_i(upd_tgt),
    .flush_i(flush), .busy_o(busy)
  );
  typedef struct {
    logic u;
    logic [31:0] upc, utgt, lpc;
    logic h;
    logic [31:0] t;
    logic w;
  } vec_t;
  vec_t tbl[19];
  bit mv[SETS][WAYS];
  logic [25:0] mt[SETS][WAYS];
  logic [31:0] mg[SETS][WAYS];
  int mrr[SETS];
  int mleft;
  function automatic vec_t v(logic u, logic [31:0] upc, logic [31:0] utgt, logic [31:0] lpc,
                             logic h, logic [31:0] t, logic w);
    vec_t r;
    r.u = u; r.upc = upc; r.utgt = utgt; r.lpc = lpc; r.h = h; r.t = t; r.w = w;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic void mreset;
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
    end
    mleft = 0;
  endfunction
  function automatic void mlook(input logic [31:0] pc, output bit h, output logic [31:0] t, output int w);
    int s = int'(pc[5:2]);
    h = 0; t = 0; w = 0;
    if (mleft > 0) return;
    for (int i = 0; i < WAYS; i++)
      if (mv[s][i] && mt[s][i] == pc[31:6]) begin h = 1; t = mg[s][i]; w = i; end
  endfunction
  function automatic void mupdate(input logic [31:0] pc, input logic [31:0] t);
    int s = int'(pc[5:2]);
    int found = -1, victim = -1;
    for (int i = 0; i < WAYS; i++) if (mv[s][i] && mt[s][i] == pc[31:6]) found = i;
    if (found >= 0) begin
      mg[s][found] = t;
      return;
    end
    for (int i = 0; i < WAYS; i++) if (!mv[s][i] && victim < 0) victim = i;
    if (victim < 0) begin
      victim = mrr[s];
      mrr[s] = (mrr[s] + 1) % WAYS;
    end
    mv[s][victim] = 1; mt[s][victim] = pc[31:6]; mg[s][victim] = t;
  endfunction
  function automatic void mstep;
    if (rst) mreset();
    else if (mleft > 0) begin
      for (int i = 0; i < WAYS; i++) mv[SETS - mleft][i] = 0;
      mrr[SETS - mleft] = 0;
      mleft--;
    end else if (flush) mleft = SETS;
    else if (upd) mupdate(upd_pc, upd_tgt);
  endfunction
  function automatic logic [31:0] rpc;
    return (32'($urandom_range(0, 4)) << 6) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
  endfunction
  initial begin
    int n;
    bit eh;
    logic [31:0] et;
    int ew;
    logic [31:0] gone[6];
    tbl[0]  = v(0, 0, 0, 'h100, 0, 0, 0);
    tbl[1]  = v(1, 'h40, 'h200, 'h40, 0, 0, 0);
    tbl[2]  = v(0, 0, 0, 'h40, 1, 'h200, 0);
    tbl[3]  = v(1, 'h40, 'hA0, 'h40, 1, 'h200, 0);
    tbl[4]  = v(1, 'h80, 'hB0, 'h40, 1, 'hA0, 0);
    tbl[5]  = v(1, 'hC0, 'hC0, 'h80, 1, 'hB0, 1);
    tbl[6]  = v(1, 'h100, 'hD0, 'hC0, 1, 'hC0, 0);
    tbl[7]  = v(0, 0, 0, 'h100, 1, 'hD0, 1);
    tbl[8]  = v(0, 0, 0, 'h40, 0, 0, 0);
    tbl[9]  = v(0, 0, 0, 'h80, 0, 0, 0);
    tbl[10] = v(0, 0, 0, 'hC0, 1, 'hC0, 0);
    tbl[11] = v(1, 'h40, 'hA0, 'h100, 1, 'hD0, 1);
    tbl[12] = v(1, 'h80, 'hB0, 'h40, 1, 'hA0, 0);
    tbl[13] = v(1, 'h80, 'h300, 'h80, 1, 'hB0, 1);
    tbl[14] = v(0, 0, 0, 'h80, 1, 'h300, 1);
    tbl[15] = v(1, 'hC0, 'hE0, 'h40, 1, 'hA0, 0);
    tbl[16] = v(0, 0, 0, 'hC0, 1, 'hE0, 0);
    tbl[17] = v(0, 0, 0, 'h40, 0, 0, 0);
    tbl[18] = v(0, 0, 0, 'h83, 1, 'h300, 1);
    rst = 1;
    tick; tick;
    rst = 0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 19; i++) begin
      upd = tbl[i].u; upd_pc = tbl[i].upc; upd_tgt = tbl[i].utgt; look = tbl[i].lpc;
      @(negedge clk);
      chk($sformatf("tbl%0d_hit", i), hit, tbl[i].h);
      chk($sformatf("tbl%0d_target", i), tgt, tbl[i].t);
      chk($sformatf("tbl%0d_way", i), way, tbl[i].w);
      tick;
    end
    upd = 1;
    upd_pc = 'h44; upd_tgt = 'h1000; tick;
    upd_pc = 'h48; upd_tgt = 'h2000; tick;
    upd_pc = 'h7C; upd_tgt = 'h3000; tick;
    upd = 0; look = 'h7C;
    @(negedge clk);
    chk("prefill_hit", hit, 1);
    chk("prefill_target", tgt, 'h3000);
    @(posedge clk); #1;
    flush = 1; tick; flush = 0;
    look = 'h44; n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      chk("flush_hit_forced_low", hit, 0);
      if (n == 1) begin upd = 1; upd_pc = 'h40; upd_tgt = 'h999; end
      else if (n == 2) begin upd = 0; flush = 1; end
      else flush = 0;
      @(posedge clk); #1;
    end
    upd = 0; flush = 0;
    chk("flush_busy_cycles", n, 16);
    gone = '{'h44, 'h48, 'h7C, 'h40, 'h80, 'hC0};
    for (int i = 0; i < 6; i++) begin
      look = gone[i]; #1;
      chk($sformatf("post_flush_miss_%h", gone[i]), hit, 0);
    end
    @(posedge clk); #1;
    upd = 1; upd_pc = 'h7C; upd_tgt = 'h3000; tick; upd = 0;
    flush = 1; tick; flush = 0;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (busy) n++;
      if (n == 5) rst = 1;
    end
    chk("rst_flush_reached_cycle5", n, 5);
    @(posedge clk); #1;
    rst = 0; look = 'h7C;
    @(negedge clk);
    chk("rst_flush_busy", busy, 0);
    chk("rst_flush_miss", hit, 0);
    @(posedge clk); #1;
    upd = 1; upd_pc = 'h40; upd_tgt = 'h777; look = 'h40;
    @(negedge clk);
    chk("rst_new_upd_same_cycle", hit, 0);
    @(posedge clk); #1;
    upd = 0;
    @(negedge clk);
    chk("rst_new_upd_hit", hit, 1);
    chk("rst_new_upd_target", tgt, 'h777);
    chk("rst_new_upd_way", way, 0);
    @(posedge clk); #1;
    rst = 1; tick; rst = 0;
    mreset();
    for (int c = 0; c < 600; c++) begin
      upd = 1'($urandom_range(0, 1));
      upd_pc = rpc();
      upd_tgt = $urandom;
      look = ($urandom_range(0, 3) == 0) ? upd_pc : rpc();
      flush = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      mlook(look, eh, et, ew);
      chk("rnd_hit", hit, eh);
      chk("rnd_target", tgt, et);
      chk("rnd_way", way, 32'(ew));
      chk("rnd_busy", busy, mleft > 0);
      mstep();
      @(posedge clk); #1;
    end
    rst = 0; upd = 0; flush = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer. Successor to the direct-mapped BTB in the fetch-stage branch predictor.
- Performs tag compare internally and returns hit/target/way for the fetch PC.
- Allocates on update with per-set round-robin replacement.
- Provides a multi-cycle flush sequencer for invalidation on context switch or fence.

Parameters:
- INDEX_WIDTH, 8, number of set-index bits; SETS = 2**INDEX_WIDTH.
- WAYS, 2, associativity; legal values 1, 2, 4.
- Derived (localparam): TAG_W = 32-INDEX_WIDTH-2; WAY_W = (WAYS>1) ? log2(WAYS) : 1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- lookup_pc_i  in  32  fetch PC to look up.
- hit_o  out  1  valid tag match found for lookup_pc_i.
- target_o  out  32  predicted target of matching way; 0 when hit_o=0.
- hit_way_o  out  WAY_W  matching way number; 0 when hit_o=0.
- upd_en_i  in  1  update request from execute stage (resolved taken branch).
- upd_pc_i  in  32  PC of resolved branch.
- upd_target_i  in  32  resolved target.
- flush_i  in  1  single-cycle request to invalidate the whole table.
- busy_o  out  1  flush sequence in progress.

Behaviour:
- Address split: set = pc[INDEX_WIDTH+1:2]; tag = pc[31:INDEX_WIDTH+2]; pc[1:0] ignored.
- Storage per set and way: valid bit, TAG_W tag, 32-bit target. Per set: WAY_W round-robin pointer rr.
- Lookup is combinational (zero latency).
  - hit_o = OR over ways of (valid & tag match) & ~busy_o.
  - At most one way can match; the update path guarantees this.
- Update is sequential; effects are visible to lookup from the cycle after upd_en_i.
  - A lookup in the same cycle as an update sees the old contents.
  - Case 1, upd tag matches a valid way w in the set: overwrite target[w]; tag and valid unchanged; rr unchanged.
  - Case 2, no match and an invalid way exists: write the lowest-numbered invalid way (valid=1, tag, target); rr unchanged.
  - Case 3, no match and set full: write way rr; rr <= rr+1 modulo WAYS.
  - WAYS=1: rr is held at 0 and the block degenerates to direct-mapped.
- Flush FSM, states IDLE and FLUSH.
  - IDLE -> FLUSH when flush_i=1. Flush counter fcnt <= 0; busy_o=1 from the next cycle.
  - In FLUSH, each cycle: clear valid of all ways in set fcnt and rr[fcnt]; fcnt <= fcnt+1.
  - FLUSH -> IDLE after the cycle with fcnt = SETS-1. busy_o is high for exactly SETS cycles.
  - In FLUSH: upd_en_i is ignored (update dropped), flush_i is ignored (no restart), hit_o forced 0.
  - flush_i and upd_en_i together in IDLE: flush wins, update dropped.
- Reset (rst_i=1 at a rising edge), including mid-flush:
  - All valid bits cleared, all rr=0, FSM=IDLE, fcnt=0.
  - busy_o=0 and hit_o=0 from the following cycle.
  - Tag and target arrays are not reset.
  - rst_i has priority over flush_i and upd_en_i.
- Outputs after reset: hit_o=0, target_o=0, hit_way_o=0, busy_o=0.

Test Plan (INDEX_WIDTH=4, WAYS=2; set = pc[5:2]):
- Reset, then lookup 0x0000_0100 -> hit_o=0, target_o=0, busy_o=0.
- Update 0x40 -> 0x200 with lookup 0x40 in the same cycle.
  - Same cycle -> hit_o=0.
  - Next cycle -> hit_o=1, target_o=0x200, hit_way_o=0.
- Conflict in set 0: update 0x40, 0x80, 0xC0, 0x100 (targets 0xA0, 0xB0, 0xC0, 0xD0) on consecutive cycles.
  - 0x40 -> way0, 0x80 -> way1.
  - 0xC0 evicts way0; 0x100 evicts way1.
  - Final state: lookup 0xC0 -> hit way0, target 0xC0; lookup 0x100 -> hit way1, target 0xD0; 0x40 and 0x80 miss.
- Update 0x40 -> 0xA0 and 0x80 -> 0xB0, then re-update 0x80 -> 0x300.
  - 0x80 hits way1 with target 0x300.
  - 0x40 still hits way0.
  - A following new tag 0xC0 evicts way0 (rr unchanged by the re-update).
- Fill several sets, pulse flush_i one cycle.
  - busy_o high exactly 16 cycles; hit_o=0 throughout.
  - upd_en_i for 0x40 during flush is dropped.
  - After busy_o falls, every previously stored PC and 0x40 miss.
- Pulse flush_i, assert rst_i on the 5th busy cycle -> busy_o=0 next cycle; all lookups miss; a new update then hits on the following cycle.
